// File: rtl/mux_pipe_stage_if.sv
// mux_pipe_stage_if: handshake/bus bundle for mux_pipe_stage.
//   master: upstream+downstream driver side (in_valid, data_in, select, flush, out_ready)
//   slave : the stage itself (in_ready, out_valid, result, sel_err)
// data_in is flattened; input k is data_in[k*WIDTH +: WIDTH].
interface mux_pipe_stage_if #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4
);
  localparam int SEL_W = $clog2(NUM_IN);

  logic                      in_valid;
  logic                      in_ready;
  logic [NUM_IN*WIDTH-1:0]   data_in;
  logic [SEL_W-1:0]          select;
  logic                      flush;
  logic                      out_valid;
  logic                      out_ready;
  logic [WIDTH-1:0]          result;
  logic                      sel_err;

  modport master (
    output in_valid, data_in, select, flush, out_ready,
    input  in_ready, out_valid, result, sel_err
  );

  modport slave (
    input  in_valid, data_in, select, flush, out_ready,
    output in_ready, out_valid, result, sel_err
  );
endinterface

// File: rtl/mux_pipe_stage.sv
// mux_pipe_stage: registered N-to-1 operand selector with valid/ready
// handshake and a two-entry skid buffer (output register + skid register).
// Ports:
//   clk   - sole clock, rising edge
//   reset - synchronous, active-high
//   bus   - mux_pipe_stage_if.slave (in_valid/in_ready/data_in/select/flush,
//           out_valid/out_ready/result/sel_err)
// in_ready is decoded from registered state only, so out_ready never reaches
// in_ready combinationally.
module mux_pipe_stage #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4,
  localparam int SEL_W = $clog2(NUM_IN)
) (
  input  logic             clk,
  input  logic             reset,
  mux_pipe_stage_if.slave  bus
);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_err_q, out_err_d;
  logic [WIDTH-1:0] skid_data_q, skid_data_d;
  logic             skid_err_q, skid_err_d;

  logic [WIDTH-1:0] cap_data;
  logic             cap_err;
  logic             accept, pop;

  // Selection happens at capture time. Default to the last input flagged as
  // an error; any in-range select overrides both.
  always_comb begin
    cap_data = bus.data_in[(NUM_IN-1)*WIDTH +: WIDTH];
    cap_err  = 1'b1;
    for (int k = 0; k < NUM_IN; k++) begin
      if (bus.select == SEL_W'(k)) begin
        cap_data = bus.data_in[k*WIDTH +: WIDTH];
        cap_err  = 1'b0;
      end
    end
  end

  assign bus.in_ready  = (state_q != TWO) && !reset;
  assign bus.out_valid = (state_q != EMPTY);
  assign bus.result    = out_data_q;
  assign bus.sel_err   = out_err_q;

  assign accept = bus.in_valid && bus.in_ready;
  assign pop    = bus.out_valid && bus.out_ready;

  always_comb begin
    state_d     = state_q;
    out_data_d  = out_data_q;
    out_err_d   = out_err_q;
    skid_data_d = skid_data_q;
    skid_err_d  = skid_err_q;

    unique case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d    = ONE;
          out_data_d = cap_data;
          out_err_d  = cap_err;
        end
      end
      ONE: begin
        if (accept && pop) begin
          out_data_d = cap_data;
          out_err_d  = cap_err;
        end else if (accept) begin
          state_d     = TWO;
          skid_data_d = cap_data;
          skid_err_d  = cap_err;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        // in_ready is low here, so only the skid-to-output move can happen.
        if (pop) begin
          state_d    = ONE;
          out_data_d = skid_data_q;
          out_err_d  = skid_err_q;
        end
      end
      default: state_d = EMPTY;
    endcase

    // Flush drops everything, including a same-cycle accept; result keeps
    // its last value so downstream sees no spurious data change.
    if (bus.flush) begin
      state_d    = EMPTY;
      out_data_d = out_data_q;
      out_err_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= EMPTY;
      out_data_q  <= '0;
      out_err_q   <= 1'b0;
      skid_data_q <= '0;
      skid_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_data_q  <= out_data_d;
      out_err_q   <= out_err_d;
      skid_data_q <= skid_data_d;
      skid_err_q  <= skid_err_d;
    end
  end

endmodule

// File: tb/tb_mux_pipe_stage.sv
// Bench for mux_pipe_stage: three instances (32b x4 inputs, 8b x5 inputs,
// 8b x3 inputs) sharing clock and reset. Inputs change and outputs are
// observed on the falling edge.
module tb_mux_pipe_stage;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mux_pipe_stage_if #(.WIDTH(32), .NUM_IN(4)) if_a ();
  mux_pipe_stage_if #(.WIDTH(8),  .NUM_IN(5)) if_b ();
  mux_pipe_stage_if #(.WIDTH(8),  .NUM_IN(3)) if_c ();

  mux_pipe_stage #(.WIDTH(32), .NUM_IN(4)) u_a (.clk(clk), .reset(reset), .bus(if_a));
  mux_pipe_stage #(.WIDTH(8),  .NUM_IN(5)) u_b (.clk(clk), .reset(reset), .bus(if_b));
  mux_pipe_stage #(.WIDTH(8),  .NUM_IN(3)) u_c (.clk(clk), .reset(reset), .bus(if_c));

  task automatic idle_all();
    if_a.in_valid = 0; if_a.flush = 0; if_a.out_ready = 0; if_a.select = '0; if_a.data_in = '0;
    if_b.in_valid = 0; if_b.flush = 0; if_b.out_ready = 0; if_b.select = '0; if_b.data_in = '0;
    if_c.in_valid = 0; if_c.flush = 0; if_c.out_ready = 0; if_c.select = '0; if_c.data_in = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (if_a.out_valid !== 1'b0 || if_a.result !== 32'h0 || if_a.sel_err !== 1'b0) begin
      errors++; $display("FAIL reset_state_a: ov=%b res=%h err=%b want 0/0/0", if_a.out_valid, if_a.result, if_a.sel_err);
    end
    checks++;
    if (if_a.in_ready !== 1'b0 || if_b.in_ready !== 1'b0 || if_c.in_ready !== 1'b0) begin
      errors++; $display("FAIL reset_in_ready_low: a=%b b=%b c=%b want 0", if_a.in_ready, if_b.in_ready, if_c.in_ready);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (if_a.in_ready !== 1'b1 || if_b.in_ready !== 1'b1 || if_c.in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready_high: a=%b b=%b c=%b want 1", if_a.in_ready, if_b.in_ready, if_c.in_ready);
    end
  endtask

  task automatic test_basic_select();
    logic [31:0] exp;
    if_a.data_in   = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    if_a.out_ready = 1'b1;
    if_a.in_valid  = 1'b1;
    if_a.select    = 2'd0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      exp = 32'h11111111 * (i + 1);
      checks++;
      if (if_a.out_valid !== 1'b1 || if_a.result !== exp || if_a.sel_err !== 1'b0) begin
        errors++; $display("FAIL basic_sel%0d: ov=%b res=%h err=%b want 1/%h/0", i, if_a.out_valid, if_a.result, if_a.sel_err, exp);
      end
      if (i < 3) if_a.select = 2'(i + 1);
      else       if_a.in_valid = 1'b0;
    end
    @(negedge clk);
    checks++;
    if (if_a.out_valid !== 1'b0) begin
      errors++; $display("FAIL basic_drain: ov=%b want 0", if_a.out_valid);
    end
  endtask

  task automatic test_out_of_range();
    for (int k = 0; k < 5; k++) if_b.data_in[k*8 +: 8] = 8'hA0 + 8'(k);
    if_b.out_ready = 1'b1;
    if_b.in_valid  = 1'b1;
    if_b.select    = 3'd7;
    @(negedge clk);
    checks++;
    if (if_b.out_valid !== 1'b1 || if_b.result !== 8'hA4 || if_b.sel_err !== 1'b1) begin
      errors++; $display("FAIL oor_sel7: ov=%b res=%h err=%b want 1/a4/1", if_b.out_valid, if_b.result, if_b.sel_err);
    end
    if_b.select = 3'd2;
    @(negedge clk);
    checks++;
    if (if_b.out_valid !== 1'b1 || if_b.result !== 8'hA2 || if_b.sel_err !== 1'b0) begin
      errors++; $display("FAIL oor_sel2: ov=%b res=%h err=%b want 1/a2/0", if_b.out_valid, if_b.result, if_b.sel_err);
    end
    if_b.in_valid = 1'b0;
    @(negedge clk);
  endtask

  // Leaves instance A holding 0x5 (output) and 0x6 (skid), out_ready=0.
  task automatic fill_two();
    if_a.out_ready = 1'b0;
    if_a.select    = 2'd0;
    if_a.in_valid  = 1'b1;
    if_a.data_in   = 128'(32'h5);
    @(negedge clk);
    if_a.data_in   = 128'(32'h6);
    @(negedge clk);
    if_a.in_valid  = 1'b0;
  endtask

  task automatic test_back_pressure();
    fill_two();
    checks++;
    if (if_a.in_ready !== 1'b0 || if_a.out_valid !== 1'b1 || if_a.result !== 32'h5) begin
      errors++; $display("FAIL skid_full: rdy=%b ov=%b res=%h want 0/1/5", if_a.in_ready, if_a.out_valid, if_a.result);
    end
    if_a.out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (if_a.in_ready !== 1'b1 || if_a.out_valid !== 1'b1 || if_a.result !== 32'h6) begin
      errors++; $display("FAIL skid_second: rdy=%b ov=%b res=%h want 1/1/6", if_a.in_ready, if_a.out_valid, if_a.result);
    end
    @(negedge clk);
    checks++;
    if (if_a.out_valid !== 1'b0) begin
      errors++; $display("FAIL skid_drain: ov=%b want 0", if_a.out_valid);
    end
  endtask

  task automatic test_flush();
    fill_two();
    if_a.flush     = 1'b1;
    if_a.out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (if_a.out_valid !== 1'b0 || if_a.in_ready !== 1'b1 || if_a.sel_err !== 1'b0) begin
      errors++; $display("FAIL flush_pop: ov=%b rdy=%b err=%b want 0/1/0", if_a.out_valid, if_a.in_ready, if_a.sel_err);
    end
    if_a.in_valid = 1'b1;
    if_a.data_in  = 128'(32'h7);
    @(negedge clk);
    checks++;
    if (if_a.out_valid !== 1'b0 || if_a.in_ready !== 1'b1) begin
      errors++; $display("FAIL flush_accept: ov=%b rdy=%b want 0/1", if_a.out_valid, if_a.in_ready);
    end
    if_a.flush    = 1'b0;
    if_a.in_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (if_a.out_valid !== 1'b0 || if_a.result !== 32'h5) begin
        errors++; $display("FAIL flush_dropped%0d: ov=%b res=%h want 0/5", i, if_a.out_valid, if_a.result);
      end
    end
  endtask

  task automatic test_reset_mid_stream();
    if_a.out_ready = 1'b1;
    if_a.in_valid  = 1'b1;
    if_a.select    = 2'd1;
    if_a.data_in   = {32'h0, 32'h0, 32'h9, 32'h0};
    @(negedge clk);
    checks++;
    if (if_a.out_valid !== 1'b1 || if_a.result !== 32'h9) begin
      errors++; $display("FAIL rst_pre: ov=%b res=%h want 1/9", if_a.out_valid, if_a.result);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (if_a.out_valid !== 1'b0 || if_a.result !== 32'h0 || if_a.sel_err !== 1'b0 || if_a.in_ready !== 1'b0) begin
      errors++; $display("FAIL rst_during: ov=%b res=%h err=%b rdy=%b want 0/0/0/0", if_a.out_valid, if_a.result, if_a.sel_err, if_a.in_ready);
    end
    reset = 1'b0;
    if_a.data_in = {32'h0, 32'h0, 32'hC, 32'h0};
    @(negedge clk);
    checks++;
    if (if_a.in_ready !== 1'b1 || if_a.out_valid !== 1'b1 || if_a.result !== 32'hC) begin
      errors++; $display("FAIL rst_post: rdy=%b ov=%b res=%h want 1/1/c", if_a.in_ready, if_a.out_valid, if_a.result);
    end
    if_a.in_valid = 1'b0;
    @(negedge clk);
  endtask

  // Reference: a FIFO of {err,value} entries capped at two; occupancy alone
  // predicts out_valid and in_ready.
  task automatic test_random_order();
    logic [8:0] q[$];
    logic [8:0] held;
    logic       stalled;
    int         idx;
    logic       acc, pp;
    logic [23:0] d;
    logic [1:0]  s;
    int          pops = 0;
    stalled = 1'b0;
    held    = '0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      @(negedge clk);
      checks++;
      if (if_c.out_valid !== (q.size() != 0) || if_c.in_ready !== (q.size() < 2)) begin
        errors++; $display("FAIL rnd_occ cyc%0d: ov=%b rdy=%b want occupancy %0d", cyc, if_c.out_valid, if_c.in_ready, q.size());
      end
      if (stalled) begin
        checks++;
        if ({if_c.sel_err, if_c.result} !== held) begin
          errors++; $display("FAIL rnd_stable cyc%0d: got %h want %h", cyc, {if_c.sel_err, if_c.result}, held);
        end
      end
      d = 24'($urandom);
      s = 2'($urandom_range(0, 3));
      if_c.data_in   = d;
      if_c.select    = s;
      if_c.in_valid  = ($urandom_range(0, 3) != 0);
      if_c.out_ready = ($urandom_range(0, 2) != 0);
      if_c.flush     = ($urandom_range(0, 63) == 0);
      acc = if_c.in_valid && (q.size() < 2);
      pp  = if_c.out_ready && (q.size() != 0);
      if (pp) begin
        checks++;
        pops++;
        if ({if_c.sel_err, if_c.result} !== q[0]) begin
          errors++; $display("FAIL rnd_data cyc%0d: got err=%b res=%h want %h", cyc, if_c.sel_err, if_c.result, q[0]);
        end
        void'(q.pop_front());
      end
      stalled = (q.size() != 0) && !pp && !if_c.flush;
      held    = {if_c.sel_err, if_c.result};
      if (if_c.flush) begin
        q.delete();
      end else if (acc) begin
        idx = (s < 3) ? int'(s) : 2;
        q.push_back({(s >= 3) ? 1'b1 : 1'b0, d[idx*8 +: 8]});
      end
    end
    @(negedge clk);
    idle_all();
    checks++;
    if (pops < 1000) begin
      errors++; $display("FAIL rnd_activity: pops=%0d want >=1000", pops);
    end
  endtask

  initial begin
    reset = 1'b1;
    idle_all();
    test_reset();
    test_basic_select();
    test_out_of_range();
    test_back_pressure();
    test_flush();
    test_reset_mid_stream();
    test_random_order();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
